// File: rtl/serial_link_pkg.sv
// Shared definitions for the serialised status link: field offsets, decoded field struct
// and the receive FSM states.
package serial_link_pkg;

  localparam int unsigned LSB_POS = 0;
  localparam int unsigned SEL_LO  = 1;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned TAG_POS = 4;
  localparam int unsigned PAD_LO  = 5;

  typedef struct packed {
    logic             lsb;
    logic [SEL_W-1:0] sel;
    logic             tag;
    logic             pad_err;
  } fields_t;

  typedef enum logic [0:0] {IDLE, SHIFT} state_e;

endpackage

// File: rtl/field_decode.sv
// Splits a packed status word into its fields; pad_err flags any non-zero pad bit.
module field_decode
  import serial_link_pkg::*;
#(
  parameter int unsigned WordWidth = 11
) (
  input  logic [WordWidth-1:0] word_i,
  output fields_t              fields_o
);

  logic pad_err;

  // A 5-bit word carries no pad bits at all.
  if (WordWidth > PAD_LO) begin : g_pad
    assign pad_err = |word_i[WordWidth-1:PAD_LO];
  end else begin : g_no_pad
    assign pad_err = 1'b0;
  end

  assign fields_o.lsb     = word_i[LSB_POS];
  assign fields_o.sel     = word_i[SEL_LO +: SEL_W];
  assign fields_o.tag     = word_i[TAG_POS];
  assign fields_o.pad_err = pad_err;

endmodule

// File: rtl/serial_field_unpacker.sv
// Deserialises LSB-first status frames and presents the decoded fields on a valid/ready port
// backed by a one-entry holding register; frames completing into a full holder are dropped.
module serial_field_unpacker
  import serial_link_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 11
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       in_valid_i,
  input  logic       in_start_i,
  input  logic       in_bit_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       out_lsb_o,
  output logic [2:0] out_sel_o,
  output logic       out_tag_o,
  output logic       out_pad_err_o,
  output logic       out_resync_o,
  output logic [7:0] out_drop_cnt_o
);

  localparam int unsigned CntW = $clog2(WORD_WIDTH);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  fields_t               hold_q, hold_d;
  logic                  valid_q, valid_d;
  logic                  resync_q, resync_d;
  logic [7:0]            drop_q, drop_d;
  logic                  complete;
  fields_t               frame_fields;

  // Decode the word including the bit arriving this cycle so completion loads it directly.
  field_decode #(
    .WordWidth(WORD_WIDTH)
  ) u_field_decode (
    .word_i  (shift_d),
    .fields_o(frame_fields)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    resync_d = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i && in_start_i) begin
          shift_d    = '0;
          shift_d[0] = in_bit_i;
          cnt_d      = CntW'(1);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (in_valid_i) begin
          if (in_start_i) begin
            shift_d    = '0;
            shift_d[0] = in_bit_i;
            cnt_d      = CntW'(1);
            resync_d   = 1'b1;
          end else begin
            shift_d[cnt_q] = in_bit_i;
            if (cnt_q == CntW'(WORD_WIDTH - 1)) begin
              complete = 1'b1;
              cnt_d    = '0;
              state_d  = IDLE;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    if (complete && (!valid_q || out_ready_i)) begin
      hold_d  = frame_fields;
      valid_d = 1'b1;
    end else begin
      if (valid_q && out_ready_i) begin
        valid_d = 1'b0;
      end
      if (complete && drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      hold_q   <= '0;
      valid_q  <= 1'b0;
      resync_q <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      hold_q   <= hold_d;
      valid_q  <= valid_d;
      resync_q <= resync_d;
      drop_q   <= drop_d;
    end
  end

  assign out_valid_o    = valid_q;
  assign out_lsb_o      = hold_q.lsb;
  assign out_sel_o      = hold_q.sel;
  assign out_tag_o      = hold_q.tag;
  assign out_pad_err_o  = hold_q.pad_err;
  assign out_resync_o   = resync_q;
  assign out_drop_cnt_o = drop_q;

endmodule

// File: tb/tb_serial_field_unpacker.sv
// Directed bench for serial_field_unpacker with hand-computed expected field values.
module tb_serial_field_unpacker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_start, in_bit;
  logic       out_valid, out_ready;
  logic       out_lsb, out_tag, out_pad_err, out_resync;
  logic [2:0] out_sel;
  logic [7:0] out_drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_field_unpacker #(
    .WORD_WIDTH(11)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .in_valid_i    (in_valid),
    .in_start_i    (in_start),
    .in_bit_i      (in_bit),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_lsb_o     (out_lsb),
    .out_sel_o     (out_sel),
    .out_tag_o     (out_tag),
    .out_pad_err_o (out_pad_err),
    .out_resync_o  (out_resync),
    .out_drop_cnt_o(out_drop_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of serial input, then sample 1 time unit after the edge.
  task automatic send_bit(input logic v, input logic s, input logic b);
    in_valid = v;
    in_start = s;
    in_bit   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_start = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic send_frame(input logic [10:0] w, input bit gaps);
    for (int i = 0; i < 11; i++) begin
      send_bit(1'b1, i == 0, w[i]);
      if (gaps && i < 10) send_bit(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic check_fields(input string tag, input logic lsb, input logic [2:0] sel,
                              input logic t, input logic pad);
    check_eq({tag, ".valid"}, out_valid, 1'b1);
    check_eq({tag, ".lsb"}, out_lsb, lsb);
    check_eq({tag, ".sel"}, out_sel, sel);
    check_eq({tag, ".tag"}, out_tag, t);
    check_eq({tag, ".pad"}, out_pad_err, pad);
  endtask

  initial begin
    logic [10:0] w;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_start  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
    #12;
    check_eq("rst.valid", out_valid, 1'b0);
    check_eq("rst.drop", out_drop_cnt, 8'd0);
    check_eq("rst.resync", out_resync, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frame 0x01B, continuous; valid must appear only after the final bit's edge.
    w = 11'h01B;
    for (int i = 0; i < 10; i++) send_bit(1'b1, i == 0, w[i]);
    check_eq("t1.early_valid", out_valid, 1'b0);
    send_bit(1'b1, 1'b0, w[10]);
    check_fields("t1", 1'b1, 3'd5, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    check_eq("t1.one_cycle", out_valid, 1'b0);

    // Frame 0x41B with gaps between every bit.
    send_frame(11'h41B, 1'b1);
    check_fields("t2", 1'b1, 3'd5, 1'b1, 1'b1);
    send_bit(1'b0, 1'b0, 1'b0);
    check_eq("t2.drain", out_valid, 1'b0);

    // Consumer stalled: second frame dropped, first held.
    out_ready = 1'b0;
    send_frame(11'h001, 1'b0);
    send_frame(11'h00E, 1'b0);
    check_fields("t3", 1'b1, 3'd0, 1'b0, 1'b0);
    check_eq("t3.drop", out_drop_cnt, 8'd1);
    out_ready = 1'b1;
    send_bit(1'b0, 1'b0, 1'b0);
    check_eq("t3.only_one", out_valid, 1'b0);

    // Accept of held word coincides with the next completion.
    out_ready = 1'b0;
    send_frame(11'h001, 1'b0);
    w = 11'h01B;
    for (int i = 0; i < 11; i++) begin
      if (i == 10) out_ready = 1'b1;
      send_bit(1'b1, i == 0, w[i]);
    end
    check_fields("t4", 1'b1, 3'd5, 1'b1, 1'b0);
    check_eq("t4.nodrop", out_drop_cnt, 8'd1);
    send_bit(1'b0, 1'b0, 1'b0);
    check_eq("t4.drain", out_valid, 1'b0);

    // Restart after 6 bits of a partial frame.
    for (int i = 0; i < 6; i++) send_bit(1'b1, i == 0, 1'b1);
    check_eq("t5.pre_resync", out_resync, 1'b0);
    w = 11'h010;
    send_bit(1'b1, 1'b1, w[0]);
    check_eq("t5.resync", out_resync, 1'b1);
    send_bit(1'b1, 1'b0, w[1]);
    check_eq("t5.resync_pulse", out_resync, 1'b0);
    for (int i = 2; i < 11; i++) send_bit(1'b1, 1'b0, w[i]);
    check_fields("t5", 1'b0, 3'd0, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    check_eq("t5.drain", out_valid, 1'b0);

    // 300 frames with no consumer: 1 held, 299 dropped on top of 1 -> saturated.
    out_ready = 1'b0;
    for (int f = 0; f < 300; f++) send_frame(11'h41B, 1'b0);
    check_eq("t6.sat", out_drop_cnt, 8'd255);
    check_fields("t6", 1'b1, 3'd5, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("t6.rst_valid", out_valid, 1'b0);
    check_eq("t6.rst_drop", out_drop_cnt, 8'd0);
    check_eq("t6.rst_fields", {out_lsb, out_sel, out_tag, out_pad_err}, 6'd0);
    check_eq("t6.rst_resync", out_resync, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Remainder of the aborted frame must not resurrect anything.
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0, 1'b1);
    check_eq("t7.no_frame", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
